// File: rtl/reg_file_sb.sv
// Register file with two write-first read ports, optional PC alias at the top index,
// and a per-register scoreboard that flags read-after-issue hazards to decode.
module reg_file_sb #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned PC_MODE = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        write_addr,
    input  logic [DATA_W-1:0]        write_data,
    input  logic [ADDR_W-1:0]        read_addr1,
    input  logic [ADDR_W-1:0]        read_addr2,
    input  logic                     use1,
    input  logic                     use2,
    output logic [DATA_W-1:0]        read_data1,
    output logic [DATA_W-1:0]        read_data2,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic [DATA_W-1:0]        pc_plus8,
    output logic                     stall,
    output logic [(2**ADDR_W)-1:0]   pending
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam logic [DEPTH-1:0] PC_MASK =
        (PC_MODE != 0) ? {1'b1, {(DEPTH-1){1'b0}}} : {DEPTH{1'b0}};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pending;

    logic              w_wr_ok;
    logic              w_byp1;
    logic              w_byp2;
    logic              w_haz1;
    logic              w_haz2;
    logic [DEPTH-1:0]  w_set;
    logic [DEPTH-1:0]  w_clr;
    logic [DEPTH-1:0]  w_pending_nxt;

    // The PC alias index is read-only: writes to it are dropped.
    assign w_wr_ok = wr_en & ~PC_MASK[write_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[write_addr] <= write_data;
        end
    end

    // Bypass is gated by reset so reads show the cleared state immediately.
    assign w_byp1 = wr_en & ~reset & (write_addr == read_addr1);
    assign w_byp2 = wr_en & ~reset & (write_addr == read_addr2);

    always_comb begin
        read_data1 = r_mem[read_addr1];
        read_data2 = r_mem[read_addr2];
        if (PC_MASK[read_addr1]) begin
            read_data1 = pc_plus8;
        end else if (w_byp1) begin
            read_data1 = write_data;
        end
        if (PC_MASK[read_addr2]) begin
            read_data2 = pc_plus8;
        end else if (w_byp2) begin
            read_data2 = write_data;
        end
    end

    // A same-edge issue beats a retiring write: the newer producer owns the register.
    always_comb begin
        w_set         = '0;
        w_clr         = '0;
        if (issue_en) begin
            w_set = (DEPTH'(1) << issue_addr) & ~PC_MASK;
        end
        if (wr_en) begin
            w_clr = DEPTH'(1) << write_addr;
        end
        w_pending_nxt = w_set | (r_pending & ~w_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign w_haz1 = use1 & r_pending[read_addr1] & ~(wr_en & (write_addr == read_addr1));
    assign w_haz2 = use2 & r_pending[read_addr2] & ~(wr_en & (write_addr == read_addr2));

    assign stall   = w_haz1 | w_haz2;
    assign pending = r_pending;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a cycle-by-cycle vector table plus hand-written
// sequences for reset contents and an asynchronous mid-cycle reset.
module tb_reg_file_sb;

    localparam logic [31:0] PC8 = 32'h0000_0108;

    typedef struct {
        logic        wr_en;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic        use1;
        logic        use2;
        logic        iss;
        logic [3:0]  ia;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_stall;
        logic [15:0] e_pend;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  write_addr = '0;
    logic [31:0] write_data = '0;
    logic [3:0]  read_addr1 = '0;
    logic [3:0]  read_addr2 = '0;
    logic        use1 = 1'b0;
    logic        use2 = 1'b0;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        issue_en = 1'b0;
    logic [3:0]  issue_addr = '0;
    logic [31:0] pc_plus8 = PC8;
    logic        stall;
    logic [15:0] pending;

    int n_vec = 0;
    int n_err = 0;

    vec_t vecs[20];

    reg_file_sb #(.DATA_W(32), .ADDR_W(4), .PC_MODE(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .use1       (use1),
        .use2       (use2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .pc_plus8   (pc_plus8),
        .stall      (stall),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                input logic [3:0] ra1, input logic [3:0] ra2,
                                input logic u1, input logic u2,
                                input logic iss, input logic [3:0] ia,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic st, input logic [15:0] pd);
        vec_t v;
        v.wr_en = we;  v.wa = wa;   v.wd = wd;
        v.ra1 = ra1;   v.ra2 = ra2; v.use1 = u1; v.use2 = u2;
        v.iss = iss;   v.ia = ia;
        v.e_rd1 = rd1; v.e_rd2 = rd2; v.e_stall = st; v.e_pend = pd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        wr_en = v.wr_en;   write_addr = v.wa;  write_data = v.wd;
        read_addr1 = v.ra1; read_addr2 = v.ra2;
        use1 = v.use1;     use2 = v.use2;
        issue_en = v.iss;  issue_addr = v.ia;
    endtask

    task automatic idle();
        wr_en = 1'b0; write_addr = '0; write_data = '0;
        read_addr1 = '0; read_addr2 = '0; use1 = 1'b0; use2 = 1'b0;
        issue_en = 1'b0; issue_addr = '0;
    endtask

    initial begin
        // Expected values are what the combinational outputs show before each edge.
        //             we  wa  wd            ra1 ra2 u1 u2 iss ia   rd1           rd2           st  pend
        vecs[0]  = mk(1, 3, 32'hDEADBEEF, 3,  0,  0, 0, 0,  0,  32'hDEADBEEF, 32'h0,        0, 16'h0000);
        vecs[1]  = mk(0, 0, 32'h0,        3,  3,  0, 0, 0,  0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 16'h0000);
        vecs[2]  = mk(1, 15, 32'h1,       15, 3,  0, 0, 0,  0,  PC8,          32'hDEADBEEF, 0, 16'h0000);
        vecs[3]  = mk(0, 0, 32'h0,        15, 0,  0, 0, 0,  0,  PC8,          32'h0,        0, 16'h0000);
        vecs[4]  = mk(0, 0, 32'h0,        0,  5,  0, 1, 1,  5,  32'h0,        32'h0,        0, 16'h0000);
        vecs[5]  = mk(0, 0, 32'h0,        0,  5,  0, 1, 0,  0,  32'h0,        32'h0,        1, 16'h0020);
        vecs[6]  = mk(0, 0, 32'h0,        0,  5,  0, 0, 0,  0,  32'h0,        32'h0,        0, 16'h0020);
        vecs[7]  = mk(1, 5, 32'h55,       0,  5,  0, 1, 0,  0,  32'h0,        32'h55,       0, 16'h0020);
        vecs[8]  = mk(0, 0, 32'h0,        0,  5,  0, 1, 0,  0,  32'h0,        32'h55,       0, 16'h0000);
        vecs[9]  = mk(1, 7, 32'h77,       7,  0,  0, 0, 1,  7,  32'h77,       32'h0,        0, 16'h0000);
        vecs[10] = mk(0, 0, 32'h0,        7,  0,  1, 0, 0,  0,  32'h77,       32'h0,        1, 16'h0080);
        vecs[11] = mk(0, 0, 32'h0,        7,  3,  1, 1, 0,  0,  32'h77,       32'hDEADBEEF, 1, 16'h0080);
        vecs[12] = mk(1, 7, 32'h777,      7,  0,  1, 0, 0,  0,  32'h777,      32'h0,        0, 16'h0080);
        vecs[13] = mk(0, 0, 32'h0,        7,  0,  1, 0, 0,  0,  32'h777,      32'h0,        0, 16'h0000);
        vecs[14] = mk(0, 0, 32'h0,        0,  0,  0, 0, 1,  15, 32'h0,        32'h0,        0, 16'h0000);
        vecs[15] = mk(0, 0, 32'h0,        15, 0,  1, 0, 0,  0,  PC8,          32'h0,        0, 16'h0000);
        vecs[16] = mk(1, 9, 32'h99,       9,  0,  0, 0, 0,  0,  32'h99,       32'h0,        0, 16'h0000);
        vecs[17] = mk(0, 0, 32'h0,        9,  2,  0, 1, 1,  2,  32'h99,       32'h0,        0, 16'h0000);
        vecs[18] = mk(0, 0, 32'h0,        2,  0,  1, 0, 1,  9,  32'h0,        32'h0,        1, 16'h0004);
        vecs[19] = mk(0, 0, 32'h0,        2,  9,  1, 0, 0,  0,  32'h0,        32'h99,       1, 16'h0204);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Post-reset contents on both ports.
        for (int i = 0; i < 16; i++) begin
            read_addr1 = 4'(i);
            read_addr2 = 4'(15 - i);
            #1;
            chk($sformatf("rst_rd1[%0d]", i), read_data1, (i == 15) ? PC8 : 32'h0);
            chk($sformatf("rst_rd2[%0d]", 15 - i), read_data2, (i == 0) ? PC8 : 32'h0);
        end
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);

        @(posedge clk);
        #1;
        for (int k = 0; k < 20; k++) begin
            drive(vecs[k]);
            #2;
            chk($sformatf("v%0d_rd1", k), read_data1, vecs[k].e_rd1);
            chk($sformatf("v%0d_rd2", k), read_data2, vecs[k].e_rd2);
            chk($sformatf("v%0d_stall", k), 32'(stall), 32'(vecs[k].e_stall));
            chk($sformatf("v%0d_pend", k), 32'(pending), 32'(vecs[k].e_pend));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a cycle with r2/r9 outstanding.
        idle();
        read_addr1 = 4'd9; use1 = 1'b1;
        read_addr2 = 4'd2; use2 = 1'b1;
        wr_en = 1'b1; write_addr = 4'd4; write_data = 32'h44;
        #2;
        chk("pre_rst_stall", 32'(stall), 32'h1);
        chk("pre_rst_pend", 32'(pending), 32'h0204);
        reset = 1'b1;
        #1;
        chk("async_rst_pend", 32'(pending), 32'h0);
        chk("async_rst_stall", 32'(stall), 32'h0);
        chk("async_rst_rd1", read_data1, 32'h0);
        chk("async_rst_rd2", read_data2, 32'h0);
        read_addr1 = 4'd4;
        #1;
        chk("rst_no_bypass", read_data1, 32'h0);
        issue_en = 1'b1; issue_addr = 4'd6;
        @(posedge clk);
        #1;
        idle();
        read_addr1 = 4'd4;
        read_addr2 = 4'd3;
        #1;
        chk("rst_wr_ignored", read_data1, 32'h0);
        chk("rst_r3_cleared", read_data2, 32'h0);
        chk("rst_iss_ignored", 32'(pending), 32'h0);
        #1 reset = 1'b0;

        // Normal operation resumes after release.
        @(posedge clk);
        #1;
        wr_en = 1'b1; write_addr = 4'd4; write_data = 32'h44;
        issue_en = 1'b1; issue_addr = 4'd6;
        read_addr1 = 4'd4;
        #2;
        chk("post_rst_bypass", read_data1, 32'h44);
        @(posedge clk);
        #1;
        idle();
        read_addr1 = 4'd4;
        read_addr2 = 4'd6; use2 = 1'b1;
        #2;
        chk("post_rst_stored", read_data1, 32'h44);
        chk("post_rst_stall", 32'(stall), 32'h1);
        chk("post_rst_pend", 32'(pending), 32'h0040);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
